// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum accumulator.
package sum_acc_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage : sum_acc_pkg

// File: rtl/acc_sat_add.sv
// Combinational ACC_W-bit accumulate step: acc + zero-extended 8-bit sample.
// carry_o always reports the true carry out of the top bit.
// Build option: define SUM_ACC_SAT_EN to clamp an overflowing result to all
// ones; otherwise the result wraps modulo 2^ACC_W.
module acc_sat_add
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [LEN_W-1:0] sample_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] raw;

    // Widen by one bit so the carry falls out of the adder directly.
    always_comb begin
        raw     = {1'b0, acc_i} + {{(ACC_W + 1 - LEN_W){1'b0}}, sample_i};
        carry_o = raw[ACC_W];
`ifdef SUM_ACC_SAT_EN
        sum_o   = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
        sum_o   = raw[ACC_W-1:0];
`endif
    end

endmodule : acc_sat_add

// File: rtl/sum_accumulator.sv
// Burst accumulator: after START it accepts LEN samples over a valid/ready
// handshake, sums them into ACC_OUT, flags overflow and pulses DONE.
// Build option: SUM_ACC_SAT_EN selects saturating accumulation (see acc_sat_add).
//
//   state | meaning
//   IDLE  | waiting for START; results of the last burst held
//   RUN   | accepting samples, SUM_READY=1, BUSY=1
//   FIN   | single-cycle DONE pulse, then back to IDLE
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic [7:0]       SUM_IN,
    input  logic             SUM_VALID,
    output logic             SUM_READY,
    output logic [ACC_W-1:0] ACC_OUT,
    output logic [LEN_W-1:0] CNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             xfer;

    acc_sat_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc_i    (acc_q),
        .sample_i (SUM_IN),
        .sum_o    (add_sum),
        .carry_o  (add_carry)
    );

    // Handshake only completes in RUN; READY is a pure state decode.
    assign xfer = SUM_VALID && (state_q == RUN);

    // Synchronous reset has priority over any transfer or START.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic; results hold by default so they persist past FIN.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    len_d   = LEN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (LEN != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + 8'd1;
                    if (add_carry) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        SUM_READY = (state_q == RUN);
        BUSY      = (state_q == RUN);
        DONE      = (state_q == FIN);
        ACC_OUT   = acc_q;
        CNT       = cnt_q;
        OVF       = ovf_q;
    end

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 16-bit and a 9-bit instance share
// the same stimulus; overflow expectations follow SUM_ACC_SAT_EN.
module tb_sum_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  sum_in;
    logic        sum_valid;

    logic        ready16, busy16, done16, ovf16;
    logic [15:0] acc16;
    logic [7:0]  cnt16;
    logic        ready9, busy9, done9, ovf9;
    logic [8:0]  acc9;
    logic [7:0]  cnt9;

    int n_checks = 0;
    int n_fail   = 0;

    sum_accumulator #(.ACC_W(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .START(start), .LEN(len),
        .SUM_IN(sum_in), .SUM_VALID(sum_valid), .SUM_READY(ready16),
        .ACC_OUT(acc16), .CNT(cnt16), .BUSY(busy16), .DONE(done16), .OVF(ovf16)
    );

    sum_accumulator #(.ACC_W(9)) dut9 (
        .CLK(clk), .RST_N(rst_n), .START(start), .LEN(len),
        .SUM_IN(sum_in), .SUM_VALID(sum_valid), .SUM_READY(ready9),
        .ACC_OUT(acc9), .CNT(cnt9), .BUSY(busy9), .DONE(done9), .OVF(ovf9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are read 1 ns after it, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] basic_vals [4];
        logic       stall_pat  [6];
        logic [7:0] ovf_vals   [3];
        int         exp_cnt;
        logic [31:0] ovf_exp;

        basic_vals = '{8'd10, 8'd20, 8'd30, 8'd40};
        stall_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ovf_vals   = '{8'd255, 8'd255, 8'd10};
`ifdef SUM_ACC_SAT_EN
        ovf_exp = 32'd511;
`else
        ovf_exp = 32'd8;
`endif

        rst_n = 1'b0; start = 1'b0; len = '0; sum_in = '0; sum_valid = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_acc",   acc16,   0);
        check("rst_cnt",   cnt16,   0);
        check("rst_ovf",   ovf16,   0);
        check("rst_done",  done16,  0);
        check("rst_busy",  busy16,  0);
        check("rst_ready", ready16, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", ready16, 0);

        // Basic burst: 10+20+30+40
        do_start(8'd4);
        check("basic_busy",  busy16,  1);
        check("basic_ready", ready16, 1);
        sum_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sum_in = basic_vals[i];
            tick();
            if (i == 2) check("basic_done_early", done16, 0);
        end
        sum_valid = 1'b0;
        check("basic_done", done16, 1);
        check("basic_acc",  acc16,  100);
        check("basic_cnt",  cnt16,  4);
        check("basic_ovf",  ovf16,  0);
        check("basic_fin_ready", ready16, 0);
        tick();
        check("basic_done_pulse", done16, 0);
        check("basic_hold_acc",   acc16,  100);
        check("basic_hold_cnt",   cnt16,  4);

        // Stall: valid pattern 1,0,0,1,0,1 with sample 5
        do_start(8'd3);
        sum_in  = 8'd5;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            sum_valid = stall_pat[i];
            tick();
            if (stall_pat[i]) exp_cnt++;
            check("stall_cnt", cnt16, exp_cnt);
            check("stall_acc", acc16, 5 * exp_cnt);
            check("stall_done", done16, (i == 5) ? 1 : 0);
        end
        sum_valid = 1'b0;
        tick();

        // Overflow: 255+255+10 (no carry at 510, carry at 520 for 9 bits)
        do_start(8'd3);
        sum_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sum_in = ovf_vals[i];
            tick();
            if (i == 1) begin
                check("ovf9_not_yet", ovf9, 0);
                check("ovf9_acc510",  acc9, 510);
            end
        end
        sum_valid = 1'b0;
        check("ovf9_flag", ovf9,  1);
        check("ovf9_acc",  acc9,  ovf_exp);
        check("ovf9_done", done9, 1);
        check("ovf16_acc", acc16, 520);
        check("ovf16_flag", ovf16, 0);
        tick();
        check("ovf9_sticky", ovf9, 1);

        // Zero length
        do_start(8'd0);
        check("zero_ready", ready16, 0);
        check("zero_busy",  busy16,  0);
        check("zero_done",  done16,  1);
        check("zero_acc",   acc16,   0);
        check("zero_ovf9",  ovf9,    0);
        tick();
        check("zero_done_pulse", done16, 0);

        // Reset in the middle of a burst, with a transfer pending
        do_start(8'd5);
        sum_valid = 1'b1;
        sum_in    = 8'd3;
        tick(); tick();
        check("mid_cnt", cnt16, 2);
        rst_n = 1'b0;
        tick();
        check("mid_rst_acc",   acc16,   0);
        check("mid_rst_cnt",   cnt16,   0);
        check("mid_rst_busy",  busy16,  0);
        check("mid_rst_ready", ready16, 0);
        check("mid_rst_done",  done16,  0);
        rst_n     = 1'b1;
        sum_valid = 1'b0;
        tick();
        check("mid_rst_no_done", done16, 0);
        do_start(8'd1);
        sum_in    = 8'd7;
        sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        check("after_rst_acc",  acc16,  7);
        check("after_rst_cnt",  cnt16,  1);
        check("after_rst_done", done16, 1);
        tick();

        // START pulsed during RUN with a shorter LEN must not matter
        do_start(8'd9);
        sum_in    = 8'd1;
        sum_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            start = (i == 1 || i == 3);
            len   = 8'd2;
            tick();
            if (i == 1) begin
                check("ign_done_at2", done16, 0);
                check("ign_busy_at2", busy16, 1);
            end
        end
        start     = 1'b0;
        sum_valid = 1'b0;
        check("ign_done", done16, 1);
        check("ign_cnt",  cnt16,  9);
        check("ign_acc",  acc16,  9);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sum_accumulator
